// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared constants, types and helpers for the fetch stage.
//  Contents : XLEN, INSTR_NOP, PC_STEP, DEFAULT_RESET_PC, fetch_entry_t,
//             word_align()
//  Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int              XLEN             = 32;
   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // One fetch-queue entry: the instruction together with the PC it came from.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Fetches are always whole words; low address bits are dropped.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : DEPTH-entry circular queue of {pc, instr} pairs between the
//             instruction memory response path and decode.
//  Ports    : clk, rstN         - clock / async active-low reset
//             i_flush           - empty the queue (wins over push/pop)
//             i_push, i_entry   - write one entry at the tail
//             i_pop             - drop the head entry
//             o_count           - number of valid entries (0..DEPTH)
//             o_head            - entry at the head (stale when empty)
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int              DEPTH    = 2,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  fetch_entry_t             i_entry,
   input  logic                     i_pop,
   output logic [$clog2(DEPTH):0]   o_count,
   output fetch_entry_t             o_head
);

   localparam int                c_AW      = $clog2(DEPTH);
   localparam logic [c_AW-1:0]   c_PTR_ONE = c_AW'(1);
   localparam logic [c_AW:0]     c_CNT_ONE = (c_AW + 1)'(1);

   fetch_entry_t      r_mem [DEPTH];
   logic [c_AW-1:0]   r_wrPtr;
   logic [c_AW-1:0]   r_rdPtr;
   logic [c_AW:0]     r_count;

   // Storage is reset too so the head reads {RESET_PC, NOP} straight out of
   // reset; DEPTH is small, so this is cheap.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '{pc: RESET_PC, instr: INSTR_NOP};
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_entry;
            r_wrPtr        <= r_wrPtr + c_PTR_ONE;   // DEPTH is a power of 2: wraps naturally
         end
         if (i_pop) begin
            r_rdPtr <= r_rdPtr + c_PTR_ONE;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;             // idle, or push+pop on any level
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rdPtr];

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Fetch stage. Holds the PC, issues in-order word fetches over a
//             req/gnt + rvalid bus, buffers responses with their PC and hands
//             them to decode over valid/ready. Redirects flush the queue and
//             discard responses of fetches already in flight.
//  Ports    : clk, rstN                    - clock / async active-low reset
//             redirectValid, redirectPc    - branch/jump redirect
//             imemReq, imemAddr, imemGnt   - fetch request channel
//             imemRvalid, imemRdata        - in-order read response
//             instrValid, instrReady,
//             instr, instrPc               - output to decode
//             fetchCnt, stallCnt           - perf counters (only when
//                                            FETCH_PERF_CNT_EN is defined)
//  Config   : FETCH_PERF_CNT_EN - adds pop and bubble-cycle counters
//  Revision : 1.0 - initial release
// ============================================================================
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             redirectValid,
   input  logic [XLEN-1:0]  redirectPc,
   output logic             imemReq,
   output logic [XLEN-1:0]  imemAddr,
   input  logic             imemGnt,
   input  logic             imemRvalid,
   input  logic [XLEN-1:0]  imemRdata,
   output logic             instrValid,
   input  logic             instrReady,
   output logic [XLEN-1:0]  instr,
   output logic [XLEN-1:0]  instrPc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]      fetchCnt,
   output logic [31:0]      stallCnt
`endif
);

   // Counters hold 0..DEPTH; the credit sum needs one extra bit.
   localparam int                   c_CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
   localparam logic [c_CNT_W:0]     c_DEPTH_V = (c_CNT_W + 1)'(DEPTH);

   logic [XLEN-1:0]     r_pc;          // next fetch address
   logic [XLEN-1:0]     r_respPc;      // PC of the next non-dropped response
   logic [c_CNT_W-1:0]  r_outstanding; // granted, response not yet seen
   logic [c_CNT_W-1:0]  r_dropCnt;     // subset of r_outstanding to discard

   logic [c_CNT_W-1:0]  w_count;
   logic [c_CNT_W:0]    w_used;
   logic                w_fire;
   logic                w_rspTaken;
   logic                w_push;
   logic                w_pop;
   logic [c_CNT_W-1:0]  w_outNext;
   logic [XLEN-1:0]     w_redirPc;
   fetch_entry_t        w_pushEntry;
   fetch_entry_t        w_head;

   // ---------------------------------------------------------------------
   //  Credit and handshakes
   // ---------------------------------------------------------------------
   // Every queue slot is either buffered or reserved by an in-flight fetch,
   // so a response can always be stored. rstN gates the request so it reads
   // low while reset is held, even though the credit terms would allow it.
   assign w_used     = {1'b0, r_outstanding} + {1'b0, w_count};
   assign imemReq    = rstN && !redirectValid && (w_used < c_DEPTH_V);
   assign imemAddr   = r_pc;
   assign w_fire     = imemReq && imemGnt;

   // A response with nothing outstanding is a protocol violation; ignore it.
   assign w_rspTaken = imemRvalid && (r_outstanding != '0);

   // Redirect discards any push or pop of the same cycle.
   assign w_push     = w_rspTaken && (r_dropCnt == '0) && !redirectValid;
   assign w_pop      = instrValid && instrReady && !redirectValid;
   assign w_redirPc  = word_align(redirectPc);

   assign w_pushEntry = '{pc: r_respPc, instr: imemRdata};

   always_comb begin
      w_outNext = r_outstanding;
      if (w_fire) begin
         w_outNext = w_outNext + c_CNT_ONE;
      end
      if (w_rspTaken) begin
         w_outNext = w_outNext - c_CNT_ONE;
      end
   end

   // ---------------------------------------------------------------------
   //  PC, response PC, outstanding and drop tracking
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_pc          <= RESET_PC;
         r_respPc      <= RESET_PC;
         r_outstanding <= '0;
         r_dropCnt     <= '0;
      end else begin
         r_outstanding <= w_outNext;
         if (redirectValid) begin
            r_pc     <= w_redirPc;
            r_respPc <= w_redirPc;
            // Drop everything still in flight after this edge. Fetches that
            // were already marked for dropping are part of r_outstanding, so
            // the new value replaces rather than adds to r_dropCnt; this keeps
            // back-to-back redirects from over-counting.
            r_dropCnt <= w_outNext;
         end else begin
            if (w_fire) begin
               r_pc <= r_pc + PC_STEP;           // wraps at 2^32
            end
            if (w_rspTaken) begin
               if (r_dropCnt != '0) begin
                  r_dropCnt <= r_dropCnt - c_CNT_ONE;
               end else begin
                  r_respPc <= r_respPc + PC_STEP;
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   //  Fetch queue
   // ---------------------------------------------------------------------
   fetch_fifo #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) u_fifo (
      .clk     (clk),
      .rstN    (rstN),
      .i_flush (redirectValid),
      .i_push  (w_push),
      .i_entry (w_pushEntry),
      .i_pop   (w_pop),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign instrValid = (w_count != '0);
   assign instr      = w_head.instr;
   assign instrPc    = w_head.pc;

   // ---------------------------------------------------------------------
   //  Optional performance counters
   // ---------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetchCnt;
   logic [31:0] r_stallCnt;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_fetchCnt <= '0;
         r_stallCnt <= '0;
      end else begin
         if (w_pop) begin
            r_fetchCnt <= r_fetchCnt + 32'd1;
         end
         // A redirect cycle is a deliberate bubble, not a fetch stall.
         if (!instrValid && !redirectValid) begin
            r_stallCnt <= r_stallCnt + 32'd1;
         end
      end
   end

   assign fetchCnt = r_fetchCnt;
   assign stallCnt = r_stallCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Self-checking bench for instr_fetch. A behavioural memory with
//             random grant and in-order random latency returns the address
//             as data; a reference model tracks the expected fetch address
//             and the expected output PC stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk;
   logic        rstN;
   logic        redirectValid;
   logic [31:0] redirectPc;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemGnt;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        instrValid;
   logic        instrReady;
   logic [31:0] instr;
   logic [31:0] instrPc;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetchCnt;
   logic [31:0] stallCnt;
`endif

   instr_fetch #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rstN          (rstN),
      .redirectValid (redirectValid),
      .redirectPc    (redirectPc),
      .imemReq       (imemReq),
      .imemAddr      (imemAddr),
      .imemGnt       (imemGnt),
      .imemRvalid    (imemRvalid),
      .imemRdata     (imemRdata),
      .instrValid    (instrValid),
      .instrReady    (instrReady),
      .instr         (instr),
      .instrPc       (instrPc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetchCnt      (fetchCnt),
      .stallCnt      (stallCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   //  Bench state
   // ---------------------------------------------------------------------
   typedef struct {
      logic [31:0] addr;
      int          rdy;      // first cycle the response may be returned
   } mreq_t;

   mreq_t       memq[$];
   int          cyc;
   int          last_rdy;
   int          gnt_pct;
   int          lat_min;
   int          lat_max;
   int          checks;
   int          failures;

   logic [31:0] exp_pc;      // PC of the next instruction decode must see
   logic [31:0] fetch_pc;    // address of the next fetch request
   int          n_pops;
   int          n_stall;
   int          n_fire;
   logic        s_valid;
   logic        s_req;
   logic [31:0] s_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle. Entered and left just after a falling edge.
   task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
      logic        fire;
      logic        pop;
      int          r;
      imemRvalid = 1'b0;
      imemRdata  = 32'h0;
      if (memq.size() > 0 && memq[0].rdy <= cyc) begin
         imemRvalid = 1'b1;
         imemRdata  = memq[0].addr;
         void'(memq.pop_front());
      end
      imemGnt       = ($urandom_range(99) < gnt_pct);
      redirectValid = redir;
      redirectPc    = rpc;
      instrReady    = rdy;
      #1;
      s_valid = instrValid;
      s_req   = imemReq;
      s_addr  = imemAddr;
      fire    = imemReq && imemGnt;
      pop     = instrValid && instrReady && !redir;
      if (redir) chk("req_in_redirect", imemReq, 1'b0);
      if (fire) begin
         chk("fetch_addr", imemAddr, fetch_pc);
         chk("credit", (memq.size() < DEPTH), 1'b1);
         r = cyc + $urandom_range(lat_max, lat_min);
         if (r <= last_rdy) r = last_rdy + 1;
         last_rdy = r;
         memq.push_back('{addr: imemAddr, rdy: r});
         fetch_pc = fetch_pc + 32'd4;
         n_fire++;
      end
      if (pop) begin
         chk("out_pc", instrPc, exp_pc);
         chk("out_instr", instr, exp_pc);
         exp_pc = exp_pc + 32'd4;
         n_pops++;
      end
      if (!instrValid && !redir) n_stall++;
      if (redir) begin
         exp_pc   = rpc & 32'hFFFF_FFFC;
         fetch_pc = rpc & 32'hFFFF_FFFC;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between edges; outputs must react at once.
   task automatic do_reset();
      #2 rstN = 1'b0;
      #1;
      chk("rst_req", imemReq, 1'b0);
      chk("rst_valid", instrValid, 1'b0);
      chk("rst_instr", instr, NOP);
      chk("rst_instrPc", instrPc, RESET_PC);
      chk("rst_addr", imemAddr, RESET_PC);
`ifdef FETCH_PERF_CNT_EN
      chk("rst_fetchCnt", fetchCnt, 32'd0);
      chk("rst_stallCnt", stallCnt, 32'd0);
`endif
      memq.delete();
      imemRvalid    = 1'b0;
      imemGnt       = 1'b0;
      redirectValid = 1'b0;
      instrReady    = 1'b0;
      exp_pc        = RESET_PC;
      fetch_pc      = RESET_PC;
      n_pops        = 0;
      n_stall       = 0;
      last_rdy      = cyc;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------
   //  Directed sequence
   // ---------------------------------------------------------------------
   initial begin
      logic found;
      checks = 0;  failures = 0;  cyc = 0;  last_rdy = 0;
      n_pops = 0;  n_stall = 0;   n_fire = 0;
      rstN = 1'b1; redirectValid = 1'b0; redirectPc = 32'h0;
      imemGnt = 1'b0; imemRvalid = 1'b0; imemRdata = 32'h0; instrReady = 1'b0;
      exp_pc = RESET_PC; fetch_pc = RESET_PC;
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      @(negedge clk);
      do_reset();

      // 1: streaming from reset, always granted, 1-cycle memory
      for (int i = 0; i < 12; i++) begin
         step(1'b0, 32'h0, 1'b1);
         if (i >= 3) chk("t1_no_gap", s_valid, 1'b1);
      end

      // 2: decode stalled -> exactly DEPTH fetches, then request held off
      step(1'b1, 32'h40, 1'b0);
      n_fire = 0;
      repeat (10) step(1'b0, 32'h0, 1'b0);
      chk("t2_fires", n_fire, DEPTH);
      chk("t2_req_blocked", s_req, 1'b0);
      chk("t2_valid_held", s_valid, 1'b1);
      repeat (12) step(1'b0, 32'h0, 1'b1);

      // 3: redirect with slow responses still in flight
      lat_min = 4; lat_max = 4;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step(1'b0, 32'h0, 1'b1);
         if (memq.size() >= 2) found = 1'b1;
      end
      chk("t3_inflight", found, 1'b1);
      step(1'b1, 32'h100, 1'b1);
      repeat (20) step(1'b0, 32'h0, 1'b1);

      // 4: misaligned redirect during simultaneous push and pop
      lat_min = 1; lat_max = 1;
      repeat (6) step(1'b0, 32'h0, 1'b1);
      chk("t4_pre_valid", s_valid, 1'b1);
      step(1'b1, 32'h203, 1'b1);
      step(1'b0, 32'h0, 1'b1);
      chk("t4_req", s_req, 1'b1);
      chk("t4_addr", s_addr, 32'h200);
      repeat (10) step(1'b0, 32'h0, 1'b1);
      // address wrap at the top of memory
      step(1'b1, 32'hFFFF_FFF6, 1'b1);
      repeat (12) step(1'b0, 32'h0, 1'b1);

      // 5: random grant, latency, ready and redirects
      gnt_pct = 50; lat_min = 1; lat_max = 4;
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(99) < 3), $urandom(), ($urandom_range(99) < 70));
      end
      repeat (4) step(1'b0, 32'h0, 1'b1);

      // 6: reset mid-stream, then restart from RESET_PC
`ifdef FETCH_PERF_CNT_EN
      chk("t6_fetchCnt", fetchCnt, n_pops);
      chk("t6_stallCnt", stallCnt, n_stall);
`endif
      do_reset();
      gnt_pct = 100; lat_min = 1; lat_max = 2;
      repeat (16) step(1'b0, 32'h0, 1'b1);
      chk("t6_restart_pc", exp_pc, RESET_PC + 32'd4 * n_pops);
      chk("t6_popped", (n_pops > 0), 1'b1);
`ifdef FETCH_PERF_CNT_EN
      chk("t6_fetchCnt_after", fetchCnt, n_pops);
      chk("t6_stallCnt_after", stallCnt, n_stall);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
